uart_rx_param: RTL

Parametrised UART receiver: the successor to the fixed 8N1, 4x-oversampled receiver.
- Configurable data width, parity mode, stop-bit count and oversampling ratio.
- 3-sample majority vote at mid-bit, with false-start rejection.
- Holds each received word behind a valid/ready handshake and flags framing, parity and overrun errors.
- Sits between the board RxD pin and the command/data consumer logic.

---
 rtl/uart_rx_param.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled, 3-sample majority vote per bit,
// false-start rejection, valid/ready output with parity/framing/overrun flags.
module uart_rx_param #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W   = $clog2(OVERSAMPLE);
  localparam int M     = OVERSAMPLE / 2;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [S_W-1:0]   S_PRE     = S_W'(M - 1);
  localparam logic [S_W-1:0]   S_MID     = S_W'(M);
  localparam logic [S_W-1:0]   S_RES     = S_W'(M + 1);
  localparam logic [S_W-1:0]   S_END     = S_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} stateT;

  stateT                state, stateNext;
  logic                 rxdMeta, rxdS, rxdPrev;
  logic [DIV_W-1:0]     tickCnt;
  logic [S_W-1:0]       sCnt;
  logic [3:0]           bitCnt;
  logic                 sampA, sampB;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 perr, ferr;
  logic                 tick, resolve, bitEnd, maj, startEdge, ferrNext, finish, parExp;

  assign tick      = (tickCnt == DIV_LAST);
  assign resolve   = tick && (sCnt == S_RES);
  assign bitEnd    = tick && (sCnt == S_END);
  assign maj       = (sampA & sampB) | (sampA & rxdS) | (sampB & rxdS);
  assign startEdge = (state == IDLE) && rxdPrev && !rxdS;
  assign ferrNext  = ferr | ((state == STOP) && resolve && !maj);
  assign parExp    = (PARITY == 1) ? ~(^shiftReg) : (^shiftReg);
  assign busy      = (state != IDLE);

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext = state;
    finish    = 1'b0;
    case (state)
      IDLE:  if (startEdge) stateNext = START;
      START: begin
        if (resolve && maj) stateNext = IDLE;
        else if (bitEnd)    stateNext = DATA;
      end
      DATA:  if (bitEnd && bitCnt == DATA_LAST) stateNext = (PARITY != 0) ? PAR : STOP;
      PAR:   if (bitEnd) stateNext = STOP;
      STOP:  begin
        // Finish at the last stop bit's resolve so the next start edge can land in its tail.
        if (resolve && bitCnt == STOP_LAST) begin
          finish    = 1'b1;
          stateNext = ferrNext ? BRK : IDLE;
        end
      end
      BRK:   if (rxdS) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: line-side flops reset to the idle level (1) so reset release never looks like a start edge.
      rxdMeta  <= 1'b1;
      rxdS     <= 1'b1;
      rxdPrev  <= 1'b1;
      tickCnt  <= '0;
      sCnt     <= '0;
      bitCnt   <= '0;
      sampA    <= 1'b1;
      sampB    <= 1'b1;
      shiftReg <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      rxdMeta <= rxd;
      rxdS    <= rxdMeta;
      rxdPrev <= rxdS;

      tickCnt <= (startEdge || tick) ? '0 : tickCnt + DIV_W'(1);

      if (state == IDLE) sCnt <= '0;
      else if (tick)     sCnt <= sCnt + S_W'(1);

      if (state != stateNext) bitCnt <= '0;
      else if (bitEnd)        bitCnt <= bitCnt + 4'd1;

      if (tick && sCnt == S_PRE) sampA <= rxdS;
      if (tick && sCnt == S_MID) sampB <= rxdS;

      if (startEdge) begin
        perr <= 1'b0;
        ferr <= 1'b0;
      end
      if (state == DATA && resolve) shiftReg <= {maj, shiftReg[DATA_BITS-1:1]};
      if (state == PAR && resolve)  perr <= (maj != parExp);
      if (state == STOP && resolve && !maj) ferr <= 1'b1;
    end
  end

  // Output holding register: a finished word is dropped only if the previous one is still unaccepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (finish) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shiftReg;
          rx_valid   <= 1'b1;
          parity_err <= perr;
          frame_err  <= ferrNext;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
